// File: rtl/secure_out_framer_pkg.sv
// Shared types and helpers for the secure output framer: FSM encoding,
// default header tag and the header word builder.
package secure_out_framer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [15:0] DEF_HDR_TAG = 16'hA55A;

  // Header layout: {tag, sequence number, payload word count}.
  function automatic logic [31:0] build_hdr(input logic [15:0] tag,
                                            input logic [7:0]  seq,
                                            input logic [7:0]  n);
    return {tag, seq, n};
  endfunction

endpackage

// File: rtl/secure_out_framer_sync_fifo.sv
// Single-clock show-ahead FIFO with explicit occupancy count; the head word
// is visible on rdata with no read latency.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are valid, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/secure_out_framer.sv
// Buffers captured memory-output words and streams them to the host as
// framed packets: header, up to FRAME_LEN payload words, XOR checksum.
module secure_out_framer
  import secure_out_framer_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          FRAME_LEN = 4,
  parameter logic [15:0] HDR_TAG   = DEF_HDR_TAG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cap_en,
  input  logic [31:0]                   cap_data,
  input  logic                          flush,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [31:0]                   m_data,
  output logic                          m_last,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          overflow
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
  localparam logic [7:0]       FRAME_N8  = 8'(FRAME_LEN);

  state_t      state;
  logic [7:0]  seq;
  logic [7:0]  n;
  logic [7:0]  cnt;
  logic [31:0] csum;
  logic [31:0] out_word;
  logic        flush_pend;

  logic        fifo_pop;
  logic [31:0] fifo_rdata;
  logic        start_frame;
  logic [7:0]  frame_n;
  logic [31:0] hdr_word;
  logic        beat;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_en),
    .pop   (fifo_pop),
    .wdata (cap_data),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign beat     = m_valid & m_ready;
  assign fifo_pop = beat && (state == S_DATA);
  assign hdr_word = build_hdr(HDR_TAG, seq, frame_n);

  // Payload comes straight from the FIFO head; header and checksum are held
  // in out_word, which is zero whenever no frame is in flight.
  assign m_data = (state == S_DATA) ? fifo_rdata : out_word;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    start_frame = 1'b0;
    frame_n     = (level >= FRAME_LVL) ? FRAME_N8 : 8'(level);
    if (state == S_IDLE && (level >= FRAME_LVL || (flush_pend && level != '0)))
      start_frame = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      seq        <= '0;
      n          <= '0;
      cnt        <= '0;
      csum       <= '0;
      out_word   <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      overflow   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      // A full FIFO drops the word even if this cycle also pops.
      if (cap_en && full) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_frame) begin
            state      <= S_HDR;
            n          <= frame_n;
            cnt        <= '0;
            out_word   <= hdr_word;
            csum       <= hdr_word;
            m_valid    <= 1'b1;
            flush_pend <= 1'b0;
          end else if (level == '0) begin
            flush_pend <= 1'b0;
          end
        end
        S_HDR: begin
          if (m_ready) state <= S_DATA;
        end
        S_DATA: begin
          if (m_ready) begin
            csum <= csum ^ fifo_rdata;
            cnt  <= cnt + 8'd1;
            if (cnt == n - 8'd1) begin
              state    <= S_CSUM;
              out_word <= csum ^ fifo_rdata;
              m_last   <= 1'b1;
            end
          end
        end
        S_CSUM: begin
          if (m_ready) begin
            state    <= S_IDLE;
            seq      <= seq + 8'd1;
            out_word <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new flush request always survives a same-cycle clear.
      if (flush) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_secure_out_framer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// each cycle against a transaction-level model (word queue + beat list).
module tb_secure_out_framer;

  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] cap_data = '0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;

  secure_out_framer #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN),
    .HDR_TAG   (16'hA55A)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: words held in the FIFO and the beats still owed to the host.
  typedef struct {
    logic [31:0] data;
    bit          payload;
  } beat_t;

  logic [31:0] q[$];
  beat_t       beats[$];
  logic [7:0]  m_seq = '0;
  bit          m_pend = 0;
  bit          m_ovf = 0;
  int          frames_done = 0;
  logic [31:0] obs[$];

  function automatic void model_reset();
    q.delete();
    beats.delete();
    m_seq  = '0;
    m_pend = 0;
    m_ovf  = 0;
  endfunction

  function automatic void build_frame();
    int          n;
    logic [31:0] hdr;
    logic [31:0] cs;
    n   = (q.size() >= FRAME_LEN) ? FRAME_LEN : q.size();
    hdr = {16'hA55A, m_seq, 8'(n)};
    cs  = hdr;
    beats.push_back('{hdr, 1'b0});
    for (int i = 0; i < n; i++) begin
      beats.push_back('{q[i], 1'b1});
      cs ^= q[i];
    end
    beats.push_back('{cs, 1'b0});
  endfunction

  function automatic void model_step();
    int    lvl0;
    bit    busy0;
    beat_t b;
    if (!reset) begin
      model_reset();
      return;
    end
    lvl0  = q.size();
    busy0 = (beats.size() != 0);
    if (busy0 && m_ready) begin
      b = beats.pop_front();
      if (b.payload) void'(q.pop_front());
      if (beats.size() == 0) begin
        m_seq++;
        frames_done++;
      end
    end else if (!busy0) begin
      if (lvl0 >= FRAME_LEN || (m_pend && lvl0 > 0)) begin
        build_frame();
        m_pend = 0;
      end else if (lvl0 == 0) begin
        m_pend = 0;
      end
    end
    if (cap_en) begin
      if (lvl0 == DEPTH) m_ovf = 1;
      else q.push_back(cap_data);
    end
    if (flush) m_pend = 1;
  endfunction

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (beats.size() != 0);
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("m_data", m_data, beats[0].data);
      check("m_last", 32'(m_last), 32'(beats.size() == 1));
    end
    check("level", 32'(level), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: compare outputs, advance the model with the driven inputs, clock.
  task automatic tick();
    check_outputs();
    if (m_valid && m_ready) obs.push_back(m_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    cap_en   = 1'b1;
    cap_data = w;
    tick();
    cap_en   = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int guard = 0;
    while ((beats.size() != 0 || q.size() >= FRAME_LEN || (m_pend && q.size() > 0))
           && guard < 500) begin
      m_ready = toggle ? ~m_ready : 1'b1;
      tick();
      guard++;
    end
    check("drain_timeout", 32'(guard >= 500), 32'd0);
  endtask

  task automatic check_absent(input logic [31:0] w);
    bit seen = 0;
    foreach (obs[i]) if (obs[i] == w) seen = 1;
    check("dropped_word_absent", 32'(seen), 32'd0);
  endtask

  initial begin
    int guard;
    int target;
    @(posedge clk);
    #1;
    // Reset state
    tick();
    check("rst_m_data", m_data, 32'd0);
    reset = 1'b1;

    // Four words, host always ready
    m_ready = 1'b1;
    obs.delete();
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    drain(0);
    check("t1_beats", 32'(obs.size()), 32'd6);
    check("t1_hdr", obs[0], 32'hA55A0004);
    check("t1_csum", obs[5], 32'hA55A0004 ^ 32'd1 ^ 32'd2 ^ 32'd3 ^ 32'd4);

    // Partial frame via flush
    obs.delete();
    push_word(32'h10);
    push_word(32'h20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(0);
    check("t2_beats", 32'(obs.size()), 32'd4);
    check("t2_hdr", obs[0], 32'hA55A0102);
    check("t2_csum", obs[3], 32'hA55A0132);

    // Host stalls every other cycle
    obs.delete();
    for (int i = 5; i <= 8; i++) begin
      m_ready = ~m_ready;
      push_word(32'(i));
    end
    drain(1);
    check("t3_beats", 32'(obs.size()), 32'd6);
    check("t3_csum", obs[5], 32'hA55A0204 ^ 32'd5 ^ 32'd6 ^ 32'd7 ^ 32'd8);

    // Overflow with a stalled host
    obs.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_word(32'h100 + 32'(i));
    tick();
    check("t4_full", 32'(full), 32'd1);
    check("t4_level", 32'(level), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    drain(0);
    check("t4_beats", 32'(obs.size()), 32'd12);
    check_absent(32'h108);

    // Reset in the middle of the payload
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
    guard = 0;
    while (beats.size() != 3 && guard < 50) begin
      tick();
      guard++;
    end
    check("t5_reach_data", 32'(guard >= 50), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    obs.delete();
    for (int i = 0; i < 4; i++) push_word(32'h300 + 32'(i));
    drain(0);
    check("t5_hdr_seq0", obs[0], 32'hA55A0004);

    // Random traffic without flush until the sequence number has wrapped
    target = frames_done + 260;
    guard  = 0;
    while (frames_done < target && guard < 20000) begin
      cap_en   = ($urandom_range(0, 99) < 60);
      cap_data = $urandom;
      m_ready  = ($urandom_range(0, 99) < 80);
      tick();
      guard++;
    end
    check("t6_timeout", 32'(guard >= 20000), 32'd0);

    // Random traffic with flush pulses
    for (int i = 0; i < 600; i++) begin
      cap_en   = ($urandom_range(0, 99) < 40);
      cap_data = $urandom;
      flush    = ($urandom_range(0, 99) < 5);
      m_ready  = ($urandom_range(0, 99) < 70);
      tick();
    end
    cap_en = 1'b0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    drain(0);
    check("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
